// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate-generator pipeline: type codes, opcodes
// and the buffer FSM encoding.
package imm_gen_pipe_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned TYPE_W = 3;

  typedef enum logic [TYPE_W-1:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_ISH  = 3'd5,
    IMM_CSR  = 3'd6,
    IMM_NONE = 3'd7
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_lane_dec.sv
// Combinational immediate decode for one instruction lane.
module imm_lane_dec
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst_i,
  input  logic              en_i,
  output logic [XLEN-1:0]   imm_c,
  output imm_type_e         type_c,
  output logic              illegal_c
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic        sext;
  logic [5:0]  shamt;

  always_comb begin
    opcode    = inst_i[6:0];
    funct3    = inst_i[14:12];
    imm32     = '0;
    sext      = 1'b0;
    type_c    = IMM_NONE;
    illegal_c = 1'b0;
    // RV64 shifts carry a 6-bit shamt; RV32 only 5
    shamt     = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
    if (en_i) begin
      case (opcode)
        OPC_LOAD, OPC_JALR: begin
          type_c = IMM_I;
          imm32  = {{20{inst_i[31]}}, inst_i[31:20]};
          sext   = 1'b1;
        end
        OPC_OP_IMM: begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            type_c = IMM_ISH;
            imm32  = {26'd0, shamt};
          end else begin
            type_c = IMM_I;
            imm32  = {{20{inst_i[31]}}, inst_i[31:20]};
            sext   = 1'b1;
          end
        end
        OPC_STORE: begin
          type_c = IMM_S;
          imm32  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
          sext   = 1'b1;
        end
        OPC_BRANCH: begin
          type_c = IMM_B;
          imm32  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                    inst_i[11:8], 1'b0};
          sext   = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: begin
          type_c = IMM_U;
          imm32  = {inst_i[31:12], 12'd0};
          sext   = 1'b1;
        end
        OPC_JAL: begin
          type_c = IMM_J;
          imm32  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                    inst_i[30:21], 1'b0};
          sext   = 1'b1;
        end
        OPC_SYSTEM: begin
          if (funct3[2]) begin
            type_c = IMM_CSR;
            imm32  = {27'd0, inst_i[19:15]};
          end
        end
        OPC_OP: begin
          type_c = IMM_NONE;
        end
        default: illegal_c = 1'b1;
      endcase
    end
    imm_c = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane immediate generator with a one-cycle output register and a
// single skid register; in_ready is registered and drops only when both are full.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned LANES = 1,
  parameter int unsigned XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*INST_W-1:0] in_inst,
  input  logic [LANES-1:0]        in_lane_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*XLEN-1:0]   out_imm,
  output logic [LANES*TYPE_W-1:0] out_imm_type,
  output logic [LANES-1:0]        out_illegal
);

  localparam logic [LANES*TYPE_W-1:0] TYPE_NONE_ALL = {LANES{TYPE_W'(IMM_NONE)}};

  logic [LANES*XLEN-1:0]   dec_imm;
  logic [LANES*TYPE_W-1:0] dec_type;
  logic [LANES-1:0]        dec_ill;

  pipe_state_e             state_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [LANES*XLEN-1:0]   out_imm_q,  skid_imm_q;
  logic [LANES*TYPE_W-1:0] out_type_q, skid_type_q;
  logic [LANES-1:0]        out_ill_q,  skid_ill_q;
  logic                    accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    imm_type_e lane_type;
    imm_lane_dec #(.XLEN(XLEN)) u_dec (
      .inst_i    (in_inst[g*INST_W +: INST_W]),
      .en_i      (in_lane_en[g]),
      .imm_c     (dec_imm[g*XLEN +: XLEN]),
      .type_c    (lane_type),
      .illegal_c (dec_ill[g])
    );
    assign dec_type[g*TYPE_W +: TYPE_W] = lane_type;
  end

  assign accept = in_valid & in_ready_q;

  // Buffer FSM: output register always holds the oldest bundle, skid the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_type_q  <= TYPE_NONE_ALL;
      out_ill_q   <= '0;
      skid_imm_q  <= '0;
      skid_type_q <= TYPE_NONE_ALL;
      skid_ill_q  <= '0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_imm_q   <= dec_imm;
            out_type_q  <= dec_type;
            out_ill_q   <= dec_ill;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            out_imm_q  <= dec_imm;
            out_type_q <= dec_type;
            out_ill_q  <= dec_ill;
          end else if (accept) begin
            skid_imm_q  <= dec_imm;
            skid_type_q <= dec_type;
            skid_ill_q  <= dec_ill;
            in_ready_q  <= 1'b0;
            state_q     <= ST_TWO;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            out_imm_q  <= skid_imm_q;
            out_type_q <= skid_type_q;
            out_ill_q  <= skid_ill_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_imm      = out_imm_q;
  assign out_imm_type = out_type_q;
  assign out_illegal  = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 1-lane/32-bit and a 4-lane/64-bit instance share
// handshakes; a queue model of buffered bundles is checked every cycle.
module tb_imm_gen_pipe;

  localparam int unsigned N = 14;
  localparam logic [31:0] VEC [N] = '{
    32'hFFF00093, 32'h01F09093, 32'hFE000FE3, 32'h123452B7, 32'h3002D073,
    32'h00000000, 32'h00B50533, 32'h00100073, 32'h8000006F, 32'hFE112E23,
    32'h03F09093, 32'h80000037, 32'hFFC12083, 32'hFE000EE3
  };

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  t;
    logic        ill;
  } res_t;

  typedef struct packed {
    logic [31:0]      imm1;
    logic [2:0]       t1;
    logic             ill1;
    logic [3:0][63:0] imm4;
    logic [3:0][2:0]  t4;
    logic [3:0]       ill4;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, flush, in_valid, out_ready;
  logic [31:0]  in_inst1;
  logic         in_en1;
  logic [127:0] in_inst4;
  logic [3:0]   in_en4;
  logic         in_ready1, out_valid1, in_ready4, out_valid4;
  logic [31:0]  out_imm1;
  logic [2:0]   out_type1;
  logic         out_ill1;
  logic [255:0] out_imm4;
  logic [11:0]  out_type4;
  logic [3:0]   out_ill4;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q[$];

  imm_gen_pipe #(.LANES(1), .XLEN(32)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_inst(in_inst1), .in_lane_en(in_en1),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_imm(out_imm1), .out_imm_type(out_type1), .out_illegal(out_ill1)
  );

  imm_gen_pipe #(.LANES(4), .XLEN(64)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_inst(in_inst4), .in_lane_en(in_en4),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_imm(out_imm4), .out_imm_type(out_type4), .out_illegal(out_ill4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode built from signed arithmetic on the whole instruction word.
  function automatic res_t model(input logic [31:0] inst, input logic en, input bit x64);
    res_t        r;
    longint      si;
    logic [6:0]  op;
    logic [2:0]  f3;
    si = longint'($signed(inst));
    op = inst[6:0];
    f3 = inst[14:12];
    r.imm = 64'd0;
    r.t   = 3'd7;
    r.ill = 1'b0;
    if (en) begin
      case (op)
        7'h03, 7'h67: begin r.t = 3'd0; r.imm = 64'(si >>> 20); end
        7'h13: begin
          if (f3 == 3'd1 || f3 == 3'd5) begin
            r.t = 3'd5;
            if (x64) r.imm = 64'(inst[25:20]);
            else     r.imm = 64'(inst[24:20]);
          end else begin
            r.t = 3'd0; r.imm = 64'(si >>> 20);
          end
        end
        7'h23: begin
          r.t = 3'd1;
          r.imm = 64'((si >>> 25) <<< 5) | 64'(inst[11:7]);
        end
        7'h63: begin
          r.t = 3'd2;
          r.imm = 64'((si >>> 31) <<< 12) | (64'(inst[7]) << 11)
                | (64'(inst[30:25]) << 5) | (64'(inst[11:8]) << 1);
        end
        7'h37, 7'h17: begin r.t = 3'd3; r.imm = 64'(si) & ~64'hFFF; end
        7'h6F: begin
          r.t = 3'd4;
          r.imm = 64'((si >>> 31) <<< 20) | (64'(inst[19:12]) << 12)
                | (64'(inst[20]) << 11) | (64'(inst[30:21]) << 1);
        end
        7'h73: if (f3[2]) begin r.t = 3'd6; r.imm = 64'(inst[19:15]); end
        7'h33: r.t = 3'd7;
        default: r.ill = 1'b1;
      endcase
    end
    if (!x64) r.imm = {32'd0, r.imm[31:0]};
    return r;
  endfunction

  function automatic exp_t expect_of(input logic [31:0] i1, input logic e1,
                                     input logic [127:0] i4, input logic [3:0] e4);
    exp_t e;
    res_t r;
    r = model(i1, e1, 1'b0);
    e.imm1 = r.imm[31:0];
    e.t1   = r.t;
    e.ill1 = r.ill;
    for (int l = 0; l < 4; l++) begin
      r = model(i4[l*32 +: 32], e4[l], 1'b1);
      e.imm4[l] = r.imm;
      e.t4[l]   = r.t;
      e.ill4[l] = r.ill;
    end
    return e;
  endfunction

  // Model state = number of buffered bundles; head is what out_* must show.
  always @(negedge clk) begin : mon
    bit ready_m;
    if (reset) begin
      q.delete();
    end else begin
      ready_m = (q.size() < 2);
      chk("out_valid1", 64'(out_valid1), 64'(q.size() != 0));
      chk("out_valid4", 64'(out_valid4), 64'(q.size() != 0));
      chk("in_ready1", 64'(in_ready1), 64'(ready_m));
      chk("in_ready4", 64'(in_ready4), 64'(ready_m));
      if (q.size() != 0) begin
        chk("imm1", 64'(out_imm1), 64'(q[0].imm1));
        chk("type1", 64'(out_type1), 64'(q[0].t1));
        chk("ill1", 64'(out_ill1), 64'(q[0].ill1));
        for (int l = 0; l < 4; l++) begin
          chk($sformatf("imm4[%0d]", l), out_imm4[l*64 +: 64], q[0].imm4[l]);
          chk($sformatf("type4[%0d]", l), 64'(out_type4[l*3 +: 3]), 64'(q[0].t4[l]));
          chk($sformatf("ill4[%0d]", l), 64'(out_ill4[l]), 64'(q[0].ill4[l]));
        end
      end
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && ready_m) q.push_back(expect_of(in_inst1, in_en1, in_inst4, in_en4));
    end
  end

  task automatic step(input logic v, input logic [31:0] i1, input logic e1,
                      input logic [127:0] i4, input logic [3:0] e4,
                      input logic r, input logic f);
    in_valid  = v;
    in_inst1  = i1;
    in_en1    = e1;
    in_inst4  = i4;
    in_en4    = e4;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] lanes4(input int k);
    return {VEC[(k+3)%N], VEC[(k+2)%N], VEC[(k+1)%N], VEC[k%N]};
  endfunction

  task automatic pin(input string name, input logic [31:0] inst, input bit x64,
                     input logic [63:0] imm, input logic [2:0] t, input logic ill);
    res_t r;
    r = model(inst, 1'b1, x64);
    chk({name, "_imm"}, r.imm, imm);
    chk({name, "_type"}, 64'(r.t), 64'(t));
    chk({name, "_ill"}, 64'(r.ill), 64'(ill));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst1 = '0; in_en1 = 1'b0; in_inst4 = '0; in_en4 = '0;

    // Hand-derived values that anchor the reference decode.
    pin("addi",  32'hFFF00093, 0, 64'hFFFFFFFF, 3'd0, 1'b0);
    pin("slli",  32'h01F09093, 0, 64'h1F, 3'd5, 1'b0);
    pin("brfe3", 32'hFE000FE3, 0, 64'hFFFFFFFE, 3'd2, 1'b0);
    pin("beq",   32'hFE000EE3, 0, 64'hFFFFFFFC, 3'd2, 1'b0);
    pin("lui",   32'h123452B7, 0, 64'h12345000, 3'd3, 1'b0);
    pin("csr",   32'h3002D073, 0, 64'h5, 3'd6, 1'b0);
    pin("jal",   32'h8000006F, 0, 64'hFFF00000, 3'd4, 1'b0);
    pin("sw",    32'hFE112E23, 0, 64'hFFFFFFFC, 3'd1, 1'b0);
    pin("sl63",  32'h03F09093, 1, 64'h3F, 3'd5, 1'b0);
    pin("sl63w", 32'h03F09093, 0, 64'h1F, 3'd5, 1'b0);
    pin("lui64", 32'h80000037, 1, 64'hFFFFFFFF80000000, 3'd3, 1'b0);
    pin("zero",  32'h00000000, 0, 64'h0, 3'd7, 1'b1);
    pin("add",   32'h00B50533, 0, 64'h0, 3'd7, 1'b0);
    pin("ebrk",  32'h00100073, 0, 64'h0, 3'd7, 1'b0);

    repeat (3) step(0, '0, 0, '0, '0, 0, 0);
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_imm1", 64'(out_imm1), 64'd0);
    chk("rst_type4", 64'(out_type4), 64'hFFF);

    // Back-to-back stream with a free-running consumer.
    for (int k = 0; k < N; k++)
      step(1, VEC[k], 1'(k % 5 != 4), lanes4(k), 4'(k * 7 + 5), 1, 0);
    repeat (2) step(0, '0, 0, '0, '0, 1, 0);

    // One-cycle latency and a mixed 4-lane bundle.
    step(1, 32'hFFF00093, 1, {32'h0000006F, 32'h123452B7, 32'h00000000, 32'hFFF00093},
         4'b0111, 1, 0);
    chk("lat_valid", 64'(out_valid1), 64'd1);
    chk("lat_imm1", 64'(out_imm1), 64'hFFFFFFFF);
    chk("l0_imm", out_imm4[63:0], 64'hFFFFFFFFFFFFFFFF);
    chk("l1_ill", 64'(out_ill4[1]), 64'd1);
    chk("l2_imm", out_imm4[191:128], 64'h0000000012345000);
    chk("l3_type", 64'(out_type4[11:9]), 64'd7);
    chk("l3_imm", out_imm4[255:192], 64'd0);
    step(0, '0, 0, '0, '0, 1, 0);

    // Stalled consumer: two bundles buffered, third refused.
    step(1, VEC[2], 1, lanes4(2), 4'hF, 0, 0);
    step(1, VEC[3], 1, lanes4(3), 4'hF, 0, 0);
    chk("stall_in_ready", 64'(in_ready1), 64'd0);
    step(1, VEC[4], 1, lanes4(4), 4'hF, 0, 0);
    step(0, '0, 0, '0, '0, 1, 0);
    chk("drain1_valid", 64'(out_valid1), 64'd1);
    step(0, '0, 0, '0, '0, 1, 0);
    chk("drain2_valid", 64'(out_valid1), 64'd0);

    // Flush while full, then flush while accepting.
    step(1, VEC[6], 1, lanes4(6), 4'hF, 0, 0);
    step(1, VEC[8], 1, lanes4(8), 4'hF, 0, 0);
    step(1, VEC[10], 1, lanes4(10), 4'hF, 0, 1);
    chk("flush_valid", 64'(out_valid1), 64'd0);
    chk("flush_ready", 64'(in_ready1), 64'd1);
    step(1, VEC[0], 1, lanes4(0), 4'hF, 0, 0);
    step(1, VEC[1], 1, lanes4(1), 4'hF, 1, 1);
    chk("flush1_valid", 64'(out_valid1), 64'd0);
    repeat (2) step(0, '0, 0, '0, '0, 1, 0);

    // Reset while one bundle is held.
    step(1, VEC[3], 1, lanes4(3), 4'hF, 0, 0);
    reset = 1'b1;
    step(0, '0, 0, '0, '0, 0, 0);
    reset = 1'b0;
    chk("rst1_valid", 64'(out_valid1), 64'd0);
    chk("rst1_imm1", 64'(out_imm1), 64'd0);
    chk("rst1_type1", 64'(out_type1), 64'd7);
    chk("rst1_imm4", 64'(|out_imm4), 64'd0);
    chk("rst1_ill4", 64'(out_ill4), 64'd0);

    // Deterministic mix of valid, backpressure and occasional flush.
    for (int c = 0; c < 90; c++)
      step(1'(c % 3 != 2), VEC[(c * 5) % N], 1'(c % 6 != 5), lanes4(c * 3),
           4'(c * 11 + 1), 1'((c % 4 != 1) ^ (c % 7 == 0)), 1'(c % 23 == 22));
    repeat (4) step(0, '0, 0, '0, '0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
